// File: rtl/sigcapture.sv
// Triggered capture buffer: records samples into a circular RAM while armed,
// freezes after trigger + post_cnt samples, then streams the buffer oldest-first.
module sigcapture #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [D_WIDTH-1:0] din,
  input  logic               arm,
  input  logic               trig,
  input  logic [A_WIDTH-1:0] post_cnt,
  output logic [D_WIDTH-1:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               armed,
  output logic               done,
  output logic [2:0]         dbg_state
);

  localparam int DEPTH = 1 << A_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_POST  = 3'd2,
    S_FETCH = 3'd3,
    S_SHOW  = 3'd4
  } state_t;

  state_t             r_state;
  logic [A_WIDTH-1:0] r_wr_ptr;
  logic [A_WIDTH-1:0] r_rd_ptr;
  logic [A_WIDTH:0]   r_fill;
  logic [A_WIDTH-1:0] r_remain;
  logic [A_WIDTH:0]   r_rd_cnt;
  logic [D_WIDTH-1:0] r_dout;
  logic               r_dout_valid;
  logic               r_armed;
  logic               r_done;
  logic [D_WIDTH-1:0] r_mem [DEPTH];

  logic               w_wr_en;
  logic [A_WIDTH-1:0] w_wr_next;
  logic               w_full;

  // Handshake: a sample transfers on the rising edge where dout_valid && dout_ready;
  // dout and dout_valid stay stable until that edge.
  assign w_wr_en   = en && (r_state == S_ARMED || r_state == S_POST);
  assign w_wr_next = r_wr_ptr + A_WIDTH'(1);
  assign w_full    = (r_fill == (A_WIDTH+1)'(DEPTH));

  // RAM contents are deliberately not reset; readout only starts after a full fill.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_remain     <= '0;
      r_rd_cnt     <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_armed      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= w_wr_next;
        if (!w_full) r_fill <= r_fill + (A_WIDTH+1)'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_state  <= S_ARMED;
            r_armed  <= 1'b1;
            r_done   <= 1'b0;
            r_wr_ptr <= '0;
            r_fill   <= '0;
          end
        end
        S_ARMED: begin
          if (trig && w_full) begin
            r_remain <= post_cnt;
            if (post_cnt == '0) begin
              r_state  <= S_FETCH;
              r_armed  <= 1'b0;
              r_rd_ptr <= en ? w_wr_next : r_wr_ptr;
              r_rd_cnt <= (A_WIDTH+1)'(DEPTH);
            end else begin
              r_state <= S_POST;
            end
          end
        end
        S_POST: begin
          if (en) begin
            r_remain <= r_remain - A_WIDTH'(1);
            if (r_remain == A_WIDTH'(1)) begin
              r_state  <= S_FETCH;
              r_armed  <= 1'b0;
              r_rd_ptr <= w_wr_next;
              r_rd_cnt <= (A_WIDTH+1)'(DEPTH);
            end
          end
        end
        S_FETCH: begin
          r_dout       <= r_mem[r_rd_ptr];
          r_dout_valid <= 1'b1;
          r_state      <= S_SHOW;
        end
        S_SHOW: begin
          if (dout_ready) begin
            r_dout_valid <= 1'b0;
            r_rd_ptr     <= r_rd_ptr + A_WIDTH'(1);
            r_rd_cnt     <= r_rd_cnt - (A_WIDTH+1)'(1);
            if (r_rd_cnt == (A_WIDTH+1)'(1)) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign armed      = r_armed;
  assign done       = r_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_sigcapture.sv
// Directed bench for sigcapture with DEPTH=16: capture, trigger rules,
// backpressure, sparse strobes, reset abort and re-arm.
module tb_sigcapture;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_POST  = 3'd2;
  localparam logic [2:0] ST_FETCH = 3'd3;
  localparam logic [2:0] ST_SHOW  = 3'd4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          arm = 1'b0;
  logic          trig = 1'b0;
  logic [AW-1:0] post_cnt = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          armed;
  logic          done;
  logic [2:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  int n = 0;
  logic [DW-1:0] exp_q[$];

  sigcapture #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .arm(arm), .trig(trig),
    .post_cnt(post_cnt), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .armed(armed), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    n = 0;
  endtask

  // One en cycle carrying the next sample number.
  task automatic push(input logic t);
    n++;
    din = DW'(n);
    en = 1'b1;
    trig = t;
    step();
    en = 1'b0;
    trig = 1'b0;
    din = 8'hEE;
  endtask

  task automatic push_n(input int cnt);
    for (int i = 0; i < cnt; i++) push(1'b0);
  endtask

  task automatic read_all(input int first);
    for (int i = 0; i < 16; i++) exp_q.push_back(DW'(first + i));
    dout_ready = 1'b1;
    while (exp_q.size() > 0) begin
      for (int k = 0; k < 8 && !dout_valid; k++) step();
      check("rd_valid", 32'(dout_valid), 32'd1);
      check("rd_data", 32'(dout), 32'(exp_q.pop_front()));
      step();
    end
    check("end_done", 32'(done), 32'd1);
    check("end_armed", 32'(armed), 32'd0);
    check("end_valid", 32'(dout_valid), 32'd0);
    check("end_state", 32'(dbg_state), 32'(ST_IDLE));
    check("end_dout", 32'(dout), 32'(first + 15));
  endtask

  initial begin
    int seen_valid;
    logic [DW-1:0] held;

    // Reset state
    step();
    step();
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_armed", 32'(armed), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    step();

    // Basic capture: trigger on sample 19, 5 post samples -> 9..24
    do_arm();
    check("arm_armed", 32'(armed), 32'd1);
    check("arm_state", 32'(dbg_state), 32'(ST_ARMED));
    push_n(18);
    post_cnt = 4'd5;
    push(1'b1);
    post_cnt = 4'd9;
    check("basic_post", 32'(dbg_state), 32'(ST_POST));
    push_n(5);
    check("basic_fetch", 32'(dbg_state), 32'(ST_FETCH));
    check("basic_fetch_valid", 32'(dout_valid), 32'd0);
    step();
    check("basic_first_valid", 32'(dout_valid), 32'd1);
    read_all(9);

    // Early trigger ignored, later trigger with post_cnt=0 -> 15..30
    do_arm();
    push_n(4);
    push(1'b1);
    seen_valid = 0;
    for (int i = 0; i < 24; i++) begin
      push(1'b0);
      if (dout_valid) seen_valid++;
    end
    check("early_no_valid", 32'(seen_valid), 32'd0);
    check("early_still_armed", 32'(dbg_state), 32'(ST_ARMED));
    post_cnt = 4'd0;
    push(1'b1);
    check("early_fetch", 32'(dbg_state), 32'(ST_FETCH));
    read_all(15);

    // post_cnt=0 on sample 19 -> 4..19, with backpressure on the first sample
    do_arm();
    push_n(18);
    post_cnt = 4'd0;
    dout_ready = 1'b0;
    push(1'b1);
    check("p0_fetch", 32'(dbg_state), 32'(ST_FETCH));
    step();
    held = dout;
    check("bp_first", 32'(held), 32'd4);
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dout_valid && dout == held) seen_valid++;
    end
    check("bp_held", 32'(seen_valid), 32'd10);
    read_all(4);

    // Sparse en: every 3rd cycle, trig at 20, post 3 -> 8..23
    do_arm();
    post_cnt = 4'd3;
    for (int i = 1; i <= 23; i++) begin
      push(i == 20);
      if (i != 23) begin
        step();
        step();
      end
    end
    check("sparse_fetch", 32'(dbg_state), 32'(ST_FETCH));
    read_all(8);

    // Reset in POST aborts immediately
    do_arm();
    push_n(18);
    post_cnt = 4'd5;
    push(1'b1);
    push_n(2);
    check("pre_rst_post", 32'(dbg_state), 32'(ST_POST));
    rst = 1'b1;
    #1;
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_rst_armed", 32'(armed), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    #1;
    rst = 1'b0;
    step();

    // Fresh capture; arm during readout ignored: trig at 20, post 2 -> 7..22
    do_arm();
    push_n(19);
    post_cnt = 4'd2;
    push(1'b1);
    push_n(2);
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("arm_in_read_state", 32'(dbg_state), 32'(ST_SHOW));
    check("arm_in_read_armed", 32'(armed), 32'd0);
    read_all(7);

    // Re-arm after done clears done; trig at 17, post 1 -> 3..18
    do_arm();
    check("rearm_done", 32'(done), 32'd0);
    check("rearm_armed", 32'(armed), 32'd1);
    push_n(16);
    post_cnt = 4'd1;
    push(1'b1);
    push_n(1);
    read_all(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
